// File: rtl/inst_fetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch buffer
// (master) and instruction memory (slave). Responses return in request order.
interface inst_fetch_buffer_if;
  logic        mem_req;
  logic [31:0] mem_address;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_address, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input mem_req, mem_address, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: issues in-order fetches for the PC register,
// parks returned words with their PCs in a DEPTH-entry FIFO for decode,
// and drops responses that belong to a flushed path.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned PCs produce a
// pre-filled entry with instr=0 and if_misaligned=1 instead of a request).
module inst_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          program_counter,
  input  logic                 chip_enable,
  output logic                 pc_ready,
  input  logic                 flush,
  inst_fetch_buffer_if.master  mem,
  output logic                 if_valid,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_instruction,
  input  logic                 id_ready,
  output logic                 if_misaligned
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][31:0] pc_q, ins_q;
  logic [DEPTH-1:0]       fill_q;
  logic [PW-1:0]          rd_ptr, wr_ptr, fill_idx;
  logic [CW-1:0]          occ, pend, discard_cnt;
  logic [CW:0]            used;
  logic                   credit, open, misal, alloc, pop, found;
  logic                   rv_drop, rv_fill, rv_any;

  // Credit counts both live slots and responses still owed to a dead path,
  // so a flushed fetch can never overrun the FIFO when its data finally lands.
  assign used   = {1'b0, occ} + {1'b0, discard_cnt};
  assign credit = used < (CW+1)'(DEPTH);

`ifdef FETCH_ALIGN_CHECK_EN
  assign misal = program_counter[1:0] != 2'b00;
`else
  assign misal = 1'b0;
`endif

  assign open            = chip_enable & ~flush & credit;
  assign mem.mem_req     = open & ~misal;
  assign mem.mem_address = program_counter;
  // A misaligned PC never goes to memory, so it is consumed without a grant.
  assign pc_ready        = open & (misal | mem.mem_gnt);
  assign alloc           = pc_ready;

  assign if_valid       = (occ != '0) & fill_q[rd_ptr] & ~flush;
  assign if_pc          = pc_q[rd_ptr];
  assign if_instruction = ins_q[rd_ptr];
  assign pop            = if_valid & id_ready;

  // Responses first pay off the discard debt; otherwise they fill the oldest
  // outstanding slot; with nothing outstanding they are ignored.
  assign rv_drop = mem.mem_rvalid & (discard_cnt != '0);
  assign rv_fill = mem.mem_rvalid & (discard_cnt == '0) & (pend != '0);
  assign rv_any  = mem.mem_rvalid & ((discard_cnt != '0) | (pend != '0));

  // Oldest allocated-but-unfilled slot; pre-filled misaligned slots are skipped.
  always_comb begin
    fill_idx = rd_ptr;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && (CW'(i) < occ) && !fill_q[rd_ptr + PW'(i)]) begin
        fill_idx = rd_ptr + PW'(i);
        found    = 1'b1;
      end
    end
  end

  // FIFO storage, pointers and in-flight bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= '0;
      ins_q       <= '0;
      fill_q      <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      pend        <= '0;
      discard_cnt <= '0;
    end else if (flush) begin
      // Everything still owed by memory for the squashed path becomes debt.
      discard_cnt <= discard_cnt + pend - CW'(rv_any);
      occ         <= '0;
      pend        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (rv_drop) discard_cnt <= discard_cnt - CW'(1);
      if (rv_fill) begin
        ins_q[fill_idx]  <= mem.mem_rdata;
        fill_q[fill_idx] <= 1'b1;
      end
      if (alloc) begin
        pc_q[wr_ptr]   <= program_counter;
        ins_q[wr_ptr]  <= '0;
        fill_q[wr_ptr] <= misal;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      occ  <= occ + CW'(alloc) - CW'(pop);
      pend <= pend + CW'(alloc & ~misal) - CW'(rv_fill);
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic [DEPTH-1:0] mis_q;

  // Per-slot misaligned flag, written alongside the PC at allocation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mis_q <= '0;
    else if (!flush && alloc) mis_q[wr_ptr] <= misal;
  end

  assign if_misaligned = if_valid & mis_q[rd_ptr];
`else
  assign if_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: an in-order memory model with
// per-request latency plus a queue-based reference of the fetch FIFO.
module tb_inst_fetch_buffer;
  localparam int DEPTH = 4;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clock = 1'b0, reset = 1'b0;
  logic [31:0] program_counter = '0;
  logic        chip_enable = 1'b0, flush = 1'b0, id_ready = 1'b0;
  logic        pc_ready, if_valid, if_misaligned;
  logic [31:0] if_pc, if_instruction;

  inst_fetch_buffer_if mif();

  inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .program_counter(program_counter),
    .chip_enable(chip_enable), .pc_ready(pc_ready), .flush(flush), .mem(mif),
    .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction),
    .id_ready(id_ready), .if_misaligned(if_misaligned)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] pc; logic [31:0] ins; bit filled; bit mis; } ent_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  ent_t mq[$];
  rsp_t rq[$];
  int   mdisc = 0, cyc = 0, last_due = -100, lat = 1;
  int   total = 0, bad = 0;
  bit   gnt = 1'b0;
  bit   e_req, e_pcr, e_val;
  logic obs_req, obs_pcr, obs_val, obs_mis;
  logic [31:0] obs_pc, obs_ins, fpc;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // One clock of stimulus: drive memory response, compare DUT against the
  // reference, advance reference and memory. Entered/left just after negedge.
  task automatic step();
    bit rv, mis, open, done;
    logic [31:0] rd;
    int unf, outst, due;
    ent_t e;
    rv = 1'b0; rd = $urandom;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      rv = 1'b1; rd = rq[0].data; void'(rq.pop_front());
    end
    mif.mem_rvalid = rv; mif.mem_rdata = rd; mif.mem_gnt = gnt;
    #1;
    mis   = ALIGN && (program_counter[1:0] != 2'b00);
    open  = chip_enable && !flush && (mq.size() + mdisc < DEPTH);
    e_req = open && !mis;
    e_pcr = open && (mis || gnt);
    e_val = mq.size() > 0 && mq[0].filled && !flush;
    obs_req = mif.mem_req; obs_pcr = pc_ready; obs_val = if_valid;
    obs_pc = if_pc; obs_ins = if_instruction; obs_mis = if_misaligned;
    total += 3;
    if (obs_req !== e_req) begin bad++; $display("FAIL mem_req cyc=%0d got %b want %b", cyc, obs_req, e_req); end
    if (obs_pcr !== e_pcr) begin bad++; $display("FAIL pc_ready cyc=%0d got %b want %b", cyc, obs_pcr, e_pcr); end
    if (obs_val !== e_val) begin bad++; $display("FAIL if_valid cyc=%0d got %b want %b", cyc, obs_val, e_val); end
    total++;
    if (obs_mis !== (e_val && mq[0].mis)) begin bad++; $display("FAIL if_misaligned cyc=%0d got %b", cyc, obs_mis); end
    if (e_req) begin
      total++;
      if (mif.mem_address !== program_counter) begin bad++; $display("FAIL mem_address cyc=%0d got %h want %h", cyc, mif.mem_address, program_counter); end
    end
    if (e_val) begin
      total += 2;
      if (obs_pc !== mq[0].pc) begin bad++; $display("FAIL if_pc cyc=%0d got %h want %h", cyc, obs_pc, mq[0].pc); end
      if (obs_ins !== mq[0].ins) begin bad++; $display("FAIL if_instruction cyc=%0d got %h want %h", cyc, obs_ins, mq[0].ins); end
    end
    if (reset) begin
      if (e_req && gnt) begin
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due;
        rq.push_back('{due: due, data: mdata(program_counter)});
      end
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      if (flush) begin
        outst = mdisc + unf;
        mdisc = outst - ((rv && outst > 0) ? 1 : 0);
        mq.delete();
      end else begin
        if (rv) begin
          if (mdisc > 0) mdisc--;
          else begin
            done = 1'b0;
            foreach (mq[i]) if (!done && !mq[i].filled) begin
              mq[i].ins = rd; mq[i].filled = 1'b1; done = 1'b1;
            end
          end
        end
        if (e_val && id_ready) void'(mq.pop_front());
        if (e_pcr) begin
          e.pc = program_counter; e.ins = '0; e.filled = mis; e.mis = mis;
          mq.push_back(e);
        end
      end
    end
    @(negedge clock);
    cyc++;
  endtask

  // Return to idle: no fetches, decode accepting, memory and debt drained.
  task automatic settle();
    int n;
    chip_enable = 1'b0; flush = 1'b0; id_ready = 1'b1;
    n = 0;
    while ((mq.size() > 0 || mdisc > 0 || rq.size() > 0) && n < 50) begin step(); n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL settle timeout q=%0d disc=%0d", mq.size(), mdisc); end
  endtask

  task automatic test_reset();
    chip_enable = 1'b0; reset = 1'b0;
    #1;
    total += 6;
    if (mif.mem_req !== 1'b0)   begin bad++; $display("FAIL rst_mem_req got %b want 0", mif.mem_req); end
    if (pc_ready !== 1'b0)      begin bad++; $display("FAIL rst_pc_ready got %b want 0", pc_ready); end
    if (if_valid !== 1'b0)      begin bad++; $display("FAIL rst_if_valid got %b want 0", if_valid); end
    if (if_misaligned !== 1'b0) begin bad++; $display("FAIL rst_if_misaligned got %b want 0", if_misaligned); end
    if (if_pc !== 32'h0)        begin bad++; $display("FAIL rst_if_pc got %h want 0", if_pc); end
    if (if_instruction !== 32'h0) begin bad++; $display("FAIL rst_if_instruction got %h want 0", if_instruction); end
    @(negedge clock); cyc++;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    lat = 1; gnt = 1'b1; id_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      chip_enable = (s < 3); program_counter = (s < 3) ? pcs[s] : 32'h0;
      step();
      if (s == 1) begin
        total++;
        if (obs_val !== 1'b0) begin bad++; $display("FAIL basic_early_valid got %b want 0", obs_val); end
      end
      if (s >= 2 && s <= 4) begin
        total += 3;
        if (obs_val !== 1'b1) begin bad++; $display("FAIL basic_valid s=%0d got %b want 1", s, obs_val); end
        if (obs_pc !== pcs[s-2]) begin bad++; $display("FAIL basic_pc s=%0d got %h want %h", s, obs_pc, pcs[s-2]); end
        if (obs_ins !== mdata(pcs[s-2])) begin bad++; $display("FAIL basic_ins s=%0d got %h want %h", s, obs_ins, mdata(pcs[s-2])); end
      end
    end
    settle();
  endtask

  task automatic test_backpressure();
    int cnt;
    lat = 1; gnt = 1'b1; id_ready = 1'b0; chip_enable = 1'b1; fpc = 32'h40; cnt = 0;
    for (int s = 0; s < 10; s++) begin
      program_counter = fpc; step();
      if (obs_pcr === 1'b1) cnt++;
      if (e_pcr) fpc += 4;
    end
    total += 2;
    if (cnt != DEPTH) begin bad++; $display("FAIL bp_accepted got %0d want %0d", cnt, DEPTH); end
    if (obs_pcr !== 1'b0) begin bad++; $display("FAIL bp_stalled got %b want 0", obs_pcr); end
    id_ready = 1'b1; program_counter = fpc; step();
    total += 2;
    if (obs_pcr !== 1'b0) begin bad++; $display("FAIL bp_full_pop_req got %b want 0", obs_pcr); end
    if (obs_pc !== 32'h40) begin bad++; $display("FAIL bp_head got %h want 40", obs_pc); end
    program_counter = fpc; step();
    total++;
    if (obs_pcr !== 1'b1) begin bad++; $display("FAIL bp_resume got %b want 1", obs_pcr); end
    chip_enable = 1'b0;
    settle();
  endtask

  task automatic test_flush();
    bit seen;
    lat = 3; gnt = 1'b1; id_ready = 1'b1;
    chip_enable = 1'b1; program_counter = 32'h200; step();
    program_counter = 32'h204; step();
    chip_enable = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    total++;
    if (int'(dut.discard_cnt) != 2) begin bad++; $display("FAIL flush_discard got %0d want 2", dut.discard_cnt); end
    chip_enable = 1'b1; program_counter = 32'h100; step();
    chip_enable = 1'b0; seen = 1'b0;
    for (int s = 0; s < 10 && !seen; s++) begin
      step();
      if (obs_val === 1'b1) begin
        seen = 1'b1;
        total += 2;
        if (obs_pc !== 32'h100) begin bad++; $display("FAIL flush_first_pc got %h want 100", obs_pc); end
        if (obs_ins !== mdata(32'h100)) begin bad++; $display("FAIL flush_first_ins got %h want %h", obs_ins, mdata(32'h100)); end
      end
    end
    total += 2;
    if (!seen) begin bad++; $display("FAIL flush_timeout got none want pc 100"); end
    if (int'(dut.discard_cnt) != 0) begin bad++; $display("FAIL flush_discard_end got %0d want 0", dut.discard_cnt); end
    settle();
  endtask

  task automatic test_flush_rvalid();
    lat = 2; gnt = 1'b1; id_ready = 1'b1;
    chip_enable = 1'b1; program_counter = 32'h300; step();
    chip_enable = 1'b0; step();
    flush = 1'b1; step();
    flush = 1'b0;
    total++;
    if (int'(dut.discard_cnt) != 0) begin bad++; $display("FAIL frv_discard got %0d want 0", dut.discard_cnt); end
    for (int s = 0; s < 3; s++) begin
      step();
      total++;
      if (obs_val !== 1'b0) begin bad++; $display("FAIL frv_stale_valid s=%0d got %b want 0", s, obs_val); end
    end
    settle();
  endtask

  task automatic test_reset_mid();
    lat = 1; gnt = 1'b1; id_ready = 1'b0; chip_enable = 1'b1;
    for (int s = 0; s < 3; s++) begin program_counter = 32'h400 + 32'(4*s); step(); end
    chip_enable = 1'b0; step(); step();
    total++;
    if (obs_val !== 1'b1) begin bad++; $display("FAIL rm_buffered got %b want 1", obs_val); end
    lat = 3; chip_enable = 1'b1; program_counter = 32'h480; step();
    chip_enable = 1'b0;
    #2 reset = 1'b0;
    #1;
    mq.delete(); mdisc = 0;
    total += 2;
    if (if_valid !== 1'b0) begin bad++; $display("FAIL rm_async_valid got %b want 0", if_valid); end
    if (if_pc !== 32'h0) begin bad++; $display("FAIL rm_async_pc got %h want 0", if_pc); end
    @(negedge clock); cyc++;
    for (int s = 0; s < 4; s++) step();
    reset = 1'b1; lat = 1; id_ready = 1'b1; chip_enable = 1'b1;
    for (int s = 0; s < 3; s++) begin program_counter = 32'h500 + 32'(4*s); step(); end
    chip_enable = 1'b0; step();
    total++;
    if (obs_pc !== 32'h504) begin bad++; $display("FAIL rm_restart_pc got %h want 504", obs_pc); end
    settle();
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_misaligned();
    lat = 1; gnt = 1'b1; id_ready = 1'b1;
    chip_enable = 1'b1; program_counter = 32'h6; step();
    total += 2;
    if (obs_req !== 1'b0) begin bad++; $display("FAIL mis_req got %b want 0", obs_req); end
    if (obs_pcr !== 1'b1) begin bad++; $display("FAIL mis_pc_ready got %b want 1", obs_pcr); end
    chip_enable = 1'b0; step();
    total += 3;
    if (obs_pc !== 32'h6) begin bad++; $display("FAIL mis_pc got %h want 6", obs_pc); end
    if (obs_mis !== 1'b1) begin bad++; $display("FAIL mis_flag got %b want 1", obs_mis); end
    if (obs_ins !== 32'h0) begin bad++; $display("FAIL mis_ins got %h want 0", obs_ins); end
    lat = 2; chip_enable = 1'b1;
    program_counter = 32'h10; step();
    program_counter = 32'h16; step();
    program_counter = 32'h20; step();
    settle();
  endtask
`endif

  task automatic test_random();
    fpc = 32'h1000;
    for (int s = 0; s < 400; s++) begin
      chip_enable = ($urandom % 4) != 0;
      gnt = ($urandom % 4) != 0;
      id_ready = ($urandom % 3) != 0;
      flush = ($urandom % 16) == 0;
      lat = 1 + ($urandom % 4);
      program_counter = fpc;
      step();
      if (flush) begin
        fpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        if (ALIGN && ($urandom % 4) == 0) fpc += 2;
      end else if (e_pcr) fpc += 4;
    end
    settle();
  endtask

  initial begin
    mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_flush_rvalid();
    test_reset_mid();
`ifdef FETCH_ALIGN_CHECK_EN
    test_misaligned();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
